// File: rtl/rect_fill_writer_if.sv
// Purpose : draw-command and RAM-write signals between the draw logic and rect_fill_writer.
// Latency : none; this is wiring only.
// Backpressure : iStall is the RAM-port hold, and it is driven by the master side.
// Ports   : master = draw logic (drives the command and stall, sees busy/done/write);
//           slave  = rect_fill_writer.
interface rect_fill_writer_if #(
   parameter int ADDR_W = 19
);
   logic              iStart;
   logic [9:0]        iX;
   logic [9:0]        iY;
   logic [6:0]        iW;
   logic [6:0]        iH;
   logic [7:0]        iColor;
   logic              iStall;
   logic              oBusy;
   logic              oDone;
   logic              oWrEn;
   logic [ADDR_W-1:0] oWrAddr;
   logic [7:0]        oWrData;

   modport master (
      output iStart, iX, iY, iW, iH, iColor, iStall,
      input  oBusy, oDone, oWrEn, oWrAddr, oWrData
   );

   modport slave (
      input  iStart, iX, iY, iW, iH, iColor, iStall,
      output oBusy, oDone, oWrEn, oWrAddr, oWrData
   );
endinterface

// File: rtl/rect_fill_writer.sv
// Purpose : fills a clipped rectangle of one colour index into the 640x480 framebuffer, in raster order.
// Latency : the first pixel appears 1 cycle after acceptance; a WxH fill takes W*H unstalled cycles, then 1 DONE cycle.
// Backpressure : iStall=1 blocks the write and holds the current pixel. iStart is only sampled in IDLE.
// Ports   : iVGA_CLK / iRST_n (async, active-low) are plain ports.
//           bus (slave) carries the command (iStart, iX, iY, iW, iH, iColor), the stall,
//           the status (oBusy, oDone) and the RAM write port (oWrEn, oWrAddr, oWrData).
module rect_fill_writer #(
   parameter int H_RES   = 640,
   parameter int V_RES   = 480,
   parameter int ADDR_W  = 19,
   parameter int MAX_DIM = 64
) (
   input  logic              iVGA_CLK,
   input  logic              iRST_n,
   rect_fill_writer_if.slave bus
);

   localparam logic [6:0]        MAX_DIM7 = 7'(MAX_DIM);
   localparam logic [10:0]       H_RES11  = 11'(H_RES);
   localparam logic [10:0]       V_RES11  = 11'(V_RES);
   localparam logic [ADDR_W-1:0] H_STRIDE = ADDR_W'(H_RES);

   typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

   state_t            state_q, state_d;
   // col/row are 11 bits, so X+W-1 (at most 1023+63) never wraps.
   logic [10:0]       col_q, col_d;
   logic [10:0]       row_q, row_d;
   logic [10:0]       x_q, x_d;
   logic [10:0]       last_col_q, last_col_d;
   logic [10:0]       last_row_q, last_row_d;
   logic [ADDR_W-1:0] row_base_q, row_base_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        color_q, color_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [6:0]        w_clamp;
   logic [6:0]        h_clamp;
   logic [ADDR_W-1:0] y_ext;

   assign w_clamp = (bus.iW > MAX_DIM7) ? MAX_DIM7 : bus.iW;
   assign h_clamp = (bus.iH > MAX_DIM7) ? MAX_DIM7 : bus.iH;
   assign y_ext   = ADDR_W'(bus.iY);

   always_comb begin
      state_d    = state_q;
      col_d      = col_q;
      row_d      = row_q;
      x_d        = x_q;
      last_col_d = last_col_q;
      last_row_d = last_row_q;
      row_base_d = row_base_q;
      color_d    = color_q;

      case (state_q)
         S_IDLE: begin
            if (bus.iStart) begin
               x_d        = 11'(bus.iX);
               col_d      = 11'(bus.iX);
               row_d      = 11'(bus.iY);
               last_col_d = 11'(bus.iX) + 11'(w_clamp) - 11'd1;
               last_row_d = 11'(bus.iY) + 11'(h_clamp) - 11'd1;
               // Y*640 done once as shift-add; per-pixel stepping below only adds.
               row_base_d = (y_ext << 9) + (y_ext << 7);
               color_d    = bus.iColor;
               state_d    = (w_clamp == 7'd0 || h_clamp == 7'd0) ? S_DONE : S_DRAW;
            end
         end
         S_DRAW: begin
            if (!bus.iStall) begin
               if (col_q == last_col_q) begin
                  if (row_q == last_row_q) begin
                     state_d = S_DONE;
                  end else begin
                     col_d      = x_q;
                     row_d      = row_q + 11'd1;
                     row_base_d = row_base_q + H_STRIDE;
                  end
               end else begin
                  col_d = col_q + 11'd1;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Off-screen pixels may wrap this adder, but they are never written.
      addr_d = row_base_d + ADDR_W'(col_d);
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state_q    <= S_IDLE;
         col_q      <= '0;
         row_q      <= '0;
         x_q        <= '0;
         last_col_q <= '0;
         last_row_q <= '0;
         row_base_q <= '0;
         addr_q     <= '0;
         color_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         col_q      <= col_d;
         row_q      <= row_d;
         x_q        <= x_d;
         last_col_q <= last_col_d;
         last_row_q <= last_row_d;
         row_base_q <= row_base_d;
         addr_q     <= addr_d;
         color_q    <= color_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // The write enable depends combinationally on iStall, so a stalled cycle
   // drops the write during that same cycle.
   assign bus.oWrEn   = (state_q == S_DRAW) & ~bus.iStall & (col_q < H_RES11) & (row_q < V_RES11);
   assign bus.oWrAddr = addr_q;
   assign bus.oWrData = color_q;
   assign bus.oBusy   = busy_q;
   assign bus.oDone   = done_q;

endmodule
